// File: rtl/inst_dispatch_queue.sv
// Instruction dispatch queue: buffers host instructions in a FIFO and issues
// them one at a time to the systolic array. Each instruction is held on
// sa_instruction until the array signals completion with a rising edge on
// sa_flag. Also tracks occupancy, retired count and a sticky timeout error.
module inst_dispatch_queue #(
  parameter int unsigned          INST_BITS      = 32,
  parameter int unsigned          DEPTH          = 8,
  parameter int unsigned          TIMEOUT_CYCLES = 4096,
  parameter logic [INST_BITS-1:0] NOP_INST       = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INST_BITS-1:0]   host_inst,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   flush,
  output logic [INST_BITS-1:0]   sa_instruction,
  input  logic                   sa_flag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            retired,
  output logic                   err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Wide enough to hold TIMEOUT_CYCLES itself; at least one bit.
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ToLast  = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [INST_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [1:0]           state_q, state_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic [15:0]          retired_q, retired_d;
  logic                 err_q, err_d;
  logic                 flag_q;
  logic                 push, pop, done;

  // host_ready depends on occupancy only, never on a same-cycle pop.
  assign host_ready     = (count_q < FullCnt);
  assign push           = host_valid && host_ready && !flush;
  assign done           = sa_flag && !flag_q;
  assign count          = count_q;
  assign sa_instruction = inst_q;
  assign retired        = retired_q;
  assign err_timeout    = err_q;
  assign busy           = (state_q != StIdle) || (count_q != '0);

  // Dispatch FSM next-state, issue register, wait counter and status.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        inst_d = NOP_INST;
        if (count_q != '0) begin
          pop     = 1'b1;
          inst_d  = mem_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Edges seen here are ignored; only WAIT observes completion.
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (done) begin
          retired_d = retired_q + 16'd1;
          inst_d    = NOP_INST;
          state_d   = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_q == ToLast)) begin
          err_d   = 1'b1;
          inst_d  = NOP_INST;
          state_d = StIdle;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        inst_d  = NOP_INST;
        state_d = StIdle;
      end
    endcase
    if (flush) begin
      state_d = StIdle;
      inst_d  = NOP_INST;
      wait_d  = '0;
      err_d   = 1'b0;
      pop     = 1'b0;
    end
  end

  // FIFO pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_inst;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      inst_q    <= NOP_INST;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      inst_q    <= inst_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      flag_q    <= sa_flag;
    end
  end

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Bench for inst_dispatch_queue: directed vectors, with issued instructions
// checked against a scoreboard queue by an independent monitor.
module tb_inst_dispatch_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] host_inst = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        flush = 1'b0;
  logic [31:0] sa_instruction;
  logic        sa_flag = 1'b0;
  logic        busy;
  logic [3:0]  count;
  logic [15:0] retired;
  logic        err_timeout;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_inst = '0;

  inst_dispatch_queue #(
    .INST_BITS     (32),
    .DEPTH         (8),
    .TIMEOUT_CYCLES(16),
    .NOP_INST      (32'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host_inst     (host_inst),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .flush         (flush),
    .sa_instruction(sa_instruction),
    .sa_flag       (sa_flag),
    .busy          (busy),
    .count         (count),
    .retired       (retired),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: each new non-NOP word on sa_instruction is one issue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_inst = '0;
    end else begin
      if (sa_instruction !== 32'h0 && sa_instruction !== prev_inst) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_issue: got 0x%0h, required none", sa_instruction);
        end else begin
          check("issue_order", sa_instruction, exp_q.pop_front());
        end
      end
      prev_inst = sa_instruction;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input bit expect_issue);
    host_inst  = w;
    host_valid = 1'b1;
    if (expect_issue) exp_q.push_back(w);
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_inst(input logic [31:0] w);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sa_instruction === w) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_issue: got 0x%0h, required 0x%0h within 60 cycles", sa_instruction, w);
    end
  endtask

  // Called with the word just issued (ISSUE); moves into WAIT then pulses flag.
  task automatic retire_pulse();
    tick();
    sa_flag = 1'b1;
    tick();
    sa_flag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    // 1) reset values, 2-cycle latency, hold until flag
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_sa_instruction", sa_instruction, 32'h0);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);

    push(32'h11, 1'b1);
    check("t1_count_after_push", 32'(count), 32'd1);
    check("t1_nop_after_1cyc", sa_instruction, 32'h0);
    tick();
    check("t1_issue_at_2cyc", sa_instruction, 32'h11);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("t1_hold", sa_instruction, 32'h11);
    sa_flag = 1'b1;
    tick();
    sa_flag = 1'b0;
    check("t1_nop_after_done", sa_instruction, 32'h0);
    check("t1_retired", 32'(retired), 32'd1);
    check("t1_busy_clear", 32'(busy), 32'd0);
    tick();

    // 2) fill to full behind one waiting word; extra push ignored
    host_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      host_inst = 32'h100 + 32'(i);
      exp_q.push_back(host_inst);
      tick();
    end
    host_valid = 1'b0;
    check("t2_count_full", 32'(count), 32'd8);
    check("t2_ready_full", 32'(host_ready), 32'd0);
    push(32'h1FF, 1'b0);
    check("t2_count_after_ignored", 32'(count), 32'd8);
    for (int i = 0; i < 9; i++) begin
      wait_inst(32'h100 + 32'(i));
      retire_pulse();
    end
    check("t2_retired", 32'(retired), 32'd10);
    check("t2_count_empty", 32'(count), 32'd0);
    tick();

    // 3) flag already high is not a completion
    sa_flag = 1'b1;
    push(32'h33, 1'b1);
    wait_inst(32'h33);
    repeat (4) tick();
    check("t3_no_retire_high", 32'(retired), 32'd10);
    check("t3_hold_high", sa_instruction, 32'h33);
    sa_flag = 1'b0;
    tick();
    sa_flag = 1'b1;
    tick();
    check("t3_retire_on_edge", 32'(retired), 32'd11);
    check("t3_nop", sa_instruction, 32'h0);
    repeat (2) tick();
    check("t3_single_retire", 32'(retired), 32'd11);
    sa_flag = 1'b0;
    tick();

    // 4) timeout after 16 WAIT cycles, next word still dispatches
    push(32'h44, 1'b1);
    push(32'h45, 1'b1);
    wait_inst(32'h44);
    repeat (16) tick();
    check("t4_no_err_yet", 32'(err_timeout), 32'd0);
    check("t4_still_held", sa_instruction, 32'h44);
    tick();
    check("t4_err_set", 32'(err_timeout), 32'd1);
    check("t4_dropped_nop", sa_instruction, 32'h0);
    check("t4_retired_same", 32'(retired), 32'd11);
    wait_inst(32'h45);
    retire_pulse();
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    check("t4_retired_next", 32'(retired), 32'd12);
    tick();

    // 5) flush with a concurrent push
    push(32'h51, 1'b1);
    push(32'h52, 1'b0);
    push(32'h53, 1'b0);
    push(32'h54, 1'b0);
    check("t5_count_3", 32'(count), 32'd3);
    check("t5_waiting", sa_instruction, 32'h51);
    flush      = 1'b1;
    host_valid = 1'b1;
    host_inst  = 32'h55;
    tick();
    flush      = 1'b0;
    host_valid = 1'b0;
    check("t5_count_0", 32'(count), 32'd0);
    check("t5_nop", sa_instruction, 32'h0);
    check("t5_err_clear", 32'(err_timeout), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_retired_kept", 32'(retired), 32'd12);
    repeat (3) tick();
    check("t5_push_discarded", 32'(count), 32'd0);

    // 6) asynchronous reset mid-WAIT
    push(32'h61, 1'b1);
    push(32'h63, 1'b0);
    wait_inst(32'h61);
    tick();
    check("t6_count_before", 32'(count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_sa_async", sa_instruction, 32'h0);
    check("t6_count_async", 32'(count), 32'd0);
    check("t6_retired_async", 32'(retired), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    check("t6_ready_async", 32'(host_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    push(32'h62, 1'b1);
    wait_inst(32'h62);
    retire_pulse();
    check("t6_retired_after", 32'(retired), 32'd1);
    check("t6_busy_after", 32'(busy), 32'd0);
    repeat (2) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
